// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives imem_addr, and buffers {pc, word} pairs in a circular prefetch queue for decode.
// Optional build macro FETCH_MISALIGN_CHK_EN: misaligned redirects halt fetch and raise fetch_fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic        pop;
  logic        push;
  logic        halt;
  logic [31:0] redirect_tgt;

`ifdef FETCH_MISALIGN_CHK_EN
  logic halt_q, halt_d;

  assign halt         = halt_q;
  assign redirect_tgt = redirect_pc;
  assign fetch_fault  = halt_q;

  // Every redirect re-evaluates the fault; only an aligned one clears it.
  always_comb begin
    halt_d = halt_q;
    if (redirect_valid) begin
      halt_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`else
  logic unused_redirect_lsbs;

  assign halt                 = 1'b0;
  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
  assign fetch_fault          = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;

  assign pop  = inst_valid && inst_ready;
  assign push = !redirect_valid && !halt && ((count_q < CW'(DEPTH)) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Flush: the word fetched this cycle and any accepted head are both dropped.
      fetch_pc_d = redirect_tgt;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      data_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
